conv_mac_stage: RTL

- Compute stage that sits directly upstream of the PE psum FIFO.
- Pops one ifmap element and one filter element per cycle from two upstream Fifo_buffer instances (PAR_READ=1) and multiply-accumulates them.
- After each group of filt_len products, scales and saturates the sum and pushes one psum into the downstream Fifo_buffer (PAR_WRITE=1).
- Repeats for num_out psums per start command.

---
 rtl/conv_mac_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/conv_mac_stage.sv
// conv_mac_stage: pops paired ifmap/filter words from two FWFT FIFOs,
// accumulates filt_len products, then pushes one scaled, saturated psum
// downstream. Repeats num_out times per start command.
module conv_mac_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_LEN    = 16,
   parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1),
   parameter int CNT_WIDTH  = 8,
   parameter int FRAC_BITS  = 0,
   parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_LEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  filt_len,
   input  logic [CNT_WIDTH-1:0]  num_out,
   input  logic [DATA_WIDTH-1:0] ifmap_din,
   input  logic                  ifmap_empty,
   output logic                  ifmap_ren,
   input  logic [DATA_WIDTH-1:0] filt_din,
   input  logic                  filt_empty,
   output logic                  filt_ren,
   output logic [DATA_WIDTH-1:0] psum_dout,
   output logic                  psum_wen,
   input  logic                  psum_full,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

   // Job parameters captured on start; later input changes are ignored.
   typedef struct packed {
      logic [LEN_WIDTH-1:0] len;
      logic [CNT_WIDTH-1:0] cnt;
   } job_cfg_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

   // Psum clamp limits expressed at accumulator width.
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   state_t                       state, state_d;
   job_cfg_t                     cfg;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic [LEN_WIDTH-1:0]         len_cnt;
   logic [CNT_WIDTH-1:0]         out_cnt;

   logic                         fire, cfg_ok, len_last, out_last;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]  acc_sum, acc_shr;
   logic [DATA_WIDTH-1:0]        sat_val;

   assign fire     = !ifmap_empty && !filt_empty;
   assign cfg_ok   = (filt_len != '0) && (filt_len <= LEN_MAX) && (num_out != '0);
   assign len_last = (len_cnt + LEN_ONE) == cfg.len;
   assign out_last = (out_cnt + CNT_ONE) == cfg.cnt;
   assign prod     = $signed(ifmap_din) * $signed(filt_din);
   assign acc_sum  = acc + ACC_WIDTH'(prod);
   assign acc_shr  = acc_sum >>> FRAC_BITS;

   // Scale-and-clamp of the group total including the product popped this cycle.
   always_comb begin
      sat_val = acc_shr[DATA_WIDTH-1:0];
      if (acc_shr > SAT_HI)      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_shr < SAT_LO) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next-state and handshake outputs; pops are always paired.
   always_comb begin
      state_d   = state;
      ifmap_ren = 1'b0;
      filt_ren  = 1'b0;
      psum_wen  = 1'b0;
      busy      = (state != IDLE);
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_d = cfg_ok ? MAC : DONE;
         MAC: begin
            ifmap_ren = fire;
            filt_ren  = fire;
            if (fire && len_last) state_d = WRITE;
         end
         WRITE: begin
            psum_wen = !psum_full;
            if (!psum_full) state_d = out_last ? DONE : MAC;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: job latch, accumulator, counters, registered psum.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg       <= '0;
         acc       <= '0;
         len_cnt   <= '0;
         out_cnt   <= '0;
         psum_dout <= '0;
      end else begin
         case (state)
            IDLE: if (start && cfg_ok) begin
               cfg.len <= filt_len;
               cfg.cnt <= num_out;
               acc     <= '0;
               len_cnt <= '0;
               out_cnt <= '0;
            end
            MAC: if (fire) begin
               acc     <= acc_sum;
               len_cnt <= len_cnt + LEN_ONE;
               if (len_last) psum_dout <= sat_val;
            end
            WRITE: if (!psum_full && !out_last) begin
               out_cnt <= out_cnt + CNT_ONE;
               acc     <= '0;
               len_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
